// File: rtl/tt_um_emern_load_sched_pkg.sv
// rtl/tt_um_emern_load_sched_pkg.sv - raster constants, FSM encoding and window helpers
package tt_um_emern_load_sched_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 480;
  localparam int MIN_WINDOW = 64;
  localparam int XFER_BITS  = 53;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  // A window is vblank, or the early part of hblank that still leaves MIN_WINDOW clks.
  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (v >= 10'(V_ACTIVE)) ||
           ((h >= 10'(H_ACTIVE)) && (h < 10'(H_TOTAL - MIN_WINDOW)));
  endfunction

  function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
    return (v < 10'(V_ACTIVE)) && (h < 10'(H_ACTIVE));
  endfunction

endpackage

// File: rtl/tt_um_emern_spi_sync.sv
// rtl/tt_um_emern_spi_sync.sv - CS/SCK synchronisers and SCK rising-edge detect
module tt_um_emern_spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_in,
  input  logic sck_in,
  output logic cs_sync,
  output logic sck_rise
);

  logic [1:0] cs_q, cs_d;
  logic [2:0] sck_q, sck_d;

  always_comb begin
    cs_d  = {cs_q[0], cs_in};
    sck_d = {sck_q[1:0], sck_in};
  end

  // CS idles high so a reset never looks like the start of a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q  <= 2'b11;
      sck_q <= 3'b000;
    end else begin
      cs_q  <= cs_d;
      sck_q <= sck_d;
    end
  end

  assign cs_sync  = cs_q[1];
  assign sck_rise = (sck_q[2:1] == 2'b01);

endmodule

// File: rtl/tt_um_emern_load_sched.sv
// rtl/tt_um_emern_load_sched.sv - gates frontend loads and host transfers to VGA blanking
module tt_um_emern_load_sched
  import tt_um_emern_load_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       disp_en,
  input  logic       cs_in,
  input  logic       sck_in,
  input  logic       overrun_clr,
  output logic       en_load,
  output logic       host_ready,
  output logic       xfer_done,
  output logic       overrun,
  output logic       frame_tick
);

  logic cs_sync;
  logic sck_rise;

  tt_um_emern_spi_sync u_spi_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_in    (cs_in),
    .sck_in   (sck_in),
    .cs_sync  (cs_sync),
    .sck_rise (sck_rise)
  );

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       en_load_q, en_load_d;
  logic       host_ready_q, host_ready_d;
  logic       xfer_done_q, xfer_done_d;
  logic       overrun_q, overrun_d;
  logic       frame_tick_q, frame_tick_d;
  logic       ovr_set;
  logic       win, active, can_open;

  assign win      = in_window(hpos, vpos);
  assign active   = in_active(hpos, vpos);
  assign can_open = win | ~disp_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xfer_done_d = 1'b0;
    ovr_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_open) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (!cs_sync) begin
          state_d = ST_XFER;
          cnt_d   = 6'd0;
        end else if (!can_open) begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // Completion outranks both CS release and the active-video abort.
        if (sck_rise && (cnt_q == 6'(XFER_BITS - 1))) begin
          xfer_done_d = 1'b1;
          state_d     = ST_DONE;
        end else if (cs_sync) begin
          state_d = can_open ? ST_OPEN : ST_IDLE;
        end else if (active && disp_en) begin
          state_d = ST_ABORT;
          ovr_set = 1'b1;
        end else if (sck_rise) begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        if (cs_sync) state_d = can_open ? ST_OPEN : ST_IDLE;
      end
      ST_ABORT: begin
        if (cs_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    en_load_d    = (state_d == ST_OPEN) || (state_d == ST_XFER);
    host_ready_d = (state_d == ST_OPEN);
    overrun_d    = ovr_set | (overrun_q & ~overrun_clr);
    frame_tick_d = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      en_load_q    <= 1'b0;
      host_ready_q <= 1'b0;
      xfer_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_load_q    <= en_load_d;
      host_ready_q <= host_ready_d;
      xfer_done_q  <= xfer_done_d;
      overrun_q    <= overrun_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign en_load    = en_load_q;
  assign host_ready = host_ready_q;
  assign xfer_done  = xfer_done_q;
  assign overrun    = overrun_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tt_um_emern_load_sched.sv
// tb/tb_tt_um_emern_load_sched.sv - directed and randomized checks of the load scheduler
module tb_tt_um_emern_load_sched;

  localparam int FRAME   = 800 * 525;
  localparam int INT_MAX = 32'h7fffffff;

  logic       clk;
  logic       rst_n, disp_en, cs_in, sck_in, overrun_clr;
  logic [9:0] hpos, vpos;
  logic       en_load, host_ready, xfer_done, overrun, frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc, lin, edge_lin;
  int done_cnt, done_edge, ovr_edge, en_low, mon_lo, mon_hi, clr_edge;
  bit ovr_seen, exp_ovr;

  tt_um_emern_load_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .disp_en     (disp_en),
    .cs_in       (cs_in),
    .sck_in      (sck_in),
    .overrun_clr (overrun_clr),
    .en_load     (en_load),
    .host_ready  (host_ready),
    .xfer_done   (xfer_done),
    .overrun     (overrun),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit win_at(input int l);
    int h = l % 800;
    int v = l / 800;
    return (v >= 480) || (h >= 640 && h < 736);
  endfunction

  function automatic bit active_at(input int l);
    return (l / 800 < 480) && (l % 800 < 640);
  endfunction

  // Raster position the DUT will see at global edge index e.
  function automatic int pos_at(input int e);
    return (lin + e - (cyc + 1)) % FRAME;
  endfunction

  // Outside a transfer, ready after an edge is just "window or display off" at that edge.
  function automatic bit exp_ready();
    return (disp_en !== 1'b1) || win_at(edge_lin);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pos(input int l);
    lin  = l;
    hpos = 10'(l % 800);
    vpos = 10'(l / 800);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (xfer_done === 1'b1) begin
      done_cnt++;
      if (done_edge < 0) done_edge = cyc;
    end
    if (overrun === 1'b1 && !ovr_seen) begin
      ovr_seen = 1'b1;
      ovr_edge = cyc;
    end
    if (cyc >= mon_lo && cyc <= mon_hi && en_load !== 1'b1) en_low++;
    edge_lin = lin;
    set_pos((lin + 1) % FRAME);
    overrun_clr = (cyc + 1 == clr_edge);
  endtask

  task automatic clear_ovr();
    overrun_clr = 1'b1;
    step();
    exp_ovr = 1'b0;
    chk1("ovr_clear", overrun, 1'b0);
  endtask

  // One host transfer of nbits SCK rises, half-period p clks; outcome predicted from raster arithmetic.
  task automatic xfer(input int p, input int nbits, input bit clr_ab);
    int t0, chi, cmp, ab, last_e, end_e;
    bit full, prior;
    full   = (nbits == 53);
    t0     = cyc;
    chi    = t0 + nbits * 2 * p + 4;
    cmp    = t0 + 105 * p + 3;
    last_e = full ? cmp - 1 : chi + 2;
    ab     = -1;
    if (disp_en === 1'b1) begin
      for (int e = t0 + 4; e <= last_e; e++) begin
        if (active_at(pos_at(e))) begin
          ab = e;
          break;
        end
      end
    end
    end_e     = (ab >= 0) ? ab : (full ? cmp : chi + 3);
    mon_lo    = t0 + 3;
    mon_hi    = end_e - 1;
    done_cnt  = 0;
    done_edge = -1;
    en_low    = 0;
    prior     = (overrun === 1'b1);
    ovr_seen  = prior;
    ovr_edge  = -1;
    clr_edge  = (clr_ab && ab >= 0) ? ab : -1;
    cs_in     = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      sck_in = 1'b0;
      repeat (p) step();
      sck_in = 1'b1;
      repeat (p) step();
    end
    sck_in = 1'b0;
    repeat (4) step();
    cs_in = 1'b1;
    step();
    step();
    chk1("ready_cs_hi_plus2", host_ready, 1'b0);
    step();
    chk1("ready_cs_hi_plus3", host_ready, (ab >= 0) ? 1'b0 : exp_ready());
    repeat (3) step();
    if (ab >= 0) exp_ovr = 1'b1;
    chkn("done_count", done_cnt, (full && ab < 0) ? 1 : 0);
    chkn("done_edge", done_edge, (full && ab < 0) ? cmp : -1);
    chk1("overrun", overrun, exp_ovr);
    if (!prior) chkn("overrun_edge", ovr_edge, ab);
    chkn("en_load_low_in_xfer", en_low, 0);
    chk1("ready_after", host_ready, exp_ready());
    mon_lo   = INT_MAX;
    mon_hi   = -1;
    clr_edge = -1;
  endtask

  initial begin
    int bad;
    rst_n       = 1'b0;
    disp_en     = 1'b1;
    cs_in       = 1'b1;
    sck_in      = 1'b0;
    overrun_clr = 1'b0;
    clr_edge    = -1;
    mon_lo      = INT_MAX;
    mon_hi      = -1;
    cyc         = 0;
    edge_lin    = 0;
    exp_ovr     = 1'b0;
    set_pos(0);
    repeat (3) step();
    chk1("rst_en_load", en_load, 1'b0);
    chk1("rst_host_ready", host_ready, 1'b0);
    chk1("rst_xfer_done", xfer_done, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_frame_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    step();

    // Display off: loads unrestricted even in active video.
    disp_en = 1'b0;
    set_pos(10 * 800);
    repeat (3) step();
    chk1("t1_pre_ready", host_ready, 1'b1);
    xfer(4, 53, 1'b0);

    // hpos sweep on an active line.
    disp_en = 1'b1;
    set_pos(10 * 800);
    bad = 0;
    repeat (800) begin
      step();
      if (host_ready !== (hpos >= 10'd641 && hpos <= 10'd736)) bad++;
      if (en_load !== (hpos >= 10'd641 && hpos <= 10'd736)) bad++;
    end
    chkn("t2_sweep_bad", bad, 0);
    set_pos(10 * 800 + 639);
    step();
    chk1("t2_h639", host_ready, 1'b0);
    step();
    chk1("t2_h640", host_ready, 1'b1);
    set_pos(10 * 800 + 735);
    step();
    chk1("t2_h735", host_ready, 1'b1);
    step();
    chk1("t2_h736", host_ready, 1'b0);
    disp_en = 1'b0;
    step();
    chk1("idle_disp_off_open", host_ready, 1'b1);
    disp_en = 1'b1;

    // Full transfer in vblank.
    set_pos(490 * 800 + 100);
    repeat (3) step();
    chk1("t3_pre_ready", host_ready, 1'b1);
    xfer(4, 53, 1'b0);

    // Transfer started late in hblank runs into the next line; clear collides with the set.
    set_pos(10 * 800 + 647);
    repeat (3) step();
    chk1("t4_pre_ready", host_ready, 1'b1);
    xfer(4, 53, 1'b1);
    repeat (20) step();
    chk1("t4_sticky", overrun, 1'b1);

    // Reset in the middle of a transfer.
    set_pos(490 * 800 + 100);
    repeat (3) step();
    cs_in = 1'b0;
    for (int b = 0; b < 30; b++) begin
      sck_in = 1'b0;
      repeat (4) step();
      sck_in = 1'b1;
      repeat (4) step();
    end
    rst_n = 1'b0;
    step();
    chk1("t6_en_load", en_load, 1'b0);
    chk1("t6_host_ready", host_ready, 1'b0);
    chk1("t6_xfer_done", xfer_done, 1'b0);
    chk1("t6_overrun", overrun, 1'b0);
    chk1("t6_frame_tick", frame_tick, 1'b0);
    cs_in  = 1'b1;
    sck_in = 1'b0;
    step();
    rst_n   = 1'b1;
    exp_ovr = 1'b0;
    repeat (3) step();
    chk1("t6_ready", host_ready, 1'b1);
    xfer(4, 53, 1'b0);

    // Abort again, then clear the sticky flag.
    set_pos(10 * 800 + 647);
    repeat (3) step();
    xfer(4, 53, 1'b0);
    clear_ovr();

    // Early CS release in vblank.
    set_pos(500 * 800 + 50);
    repeat (3) step();
    xfer(3, 20, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int p, nb, l;
      bit clr;
      p   = int'($urandom_range(1, 6));
      nb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 52)) : 53;
      clr = 1'($urandom_range(0, 1));
      disp_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        l = int'($urandom_range(480, 524)) * 800 + int'($urandom_range(0, 770));
      else
        l = int'($urandom_range(0, 478)) * 800 + int'($urandom_range(640, 712));
      clear_ovr();
      set_pos(l);
      repeat (3) step();
      chk1("rnd_pre_ready", host_ready, exp_ready());
      xfer(p, nb, clr);
    end

    disp_en = 1'b0;
    set_pos(479 * 800 + 797);
    repeat (6) begin
      step();
      chk1("frame_tick", frame_tick, edge_lin == 480 * 800);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
